// File: rtl/gauss_window_gen_if.sv
// Pixel-stream bundle for the 3x3 window generator: raster input side
// plus the registered window output side.
interface gauss_window_gen_if #(
  parameter int DATA_W = 8
) ();
  logic                  in_valid;
  logic                  in_sof;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid;
  logic [9*DATA_W-1:0]   out_window;
  logic                  out_eof;

  // The pixel source drives the inputs and consumes the windows.
  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, out_window, out_eof
  );

  // The window generator accepts pixels and produces windows.
  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, out_window, out_eof
  );
endinterface

// File: rtl/gauss_window_gen.sv
// 3x3 sliding-window generator for a raster pixel stream: two line buffers
// feed a register window; interior windows are emitted one cycle after the pixel.
module gauss_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst,
  gauss_window_gen_if.slave bus
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_MIN  = XW'(2);
  localparam logic [YW-1:0] Y_MIN  = YW'(2);

  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;
  logic          accept;
  logic          emit;

  logic [DATA_W-1:0] lb1_mem [IMG_W];
  logic [DATA_W-1:0] lb2_mem [IMG_W];
  logic [DATA_W-1:0] lb1_rd;
  logic [DATA_W-1:0] lb2_rd;

  logic [8:0][DATA_W-1:0] win_q, win_d;
  logic [8:0][DATA_W-1:0] out_win_q, out_win_d;
  logic                   out_vld_q, out_vld_d;
  logic                   out_eof_q, out_eof_d;

  // Stage 0: position of the incoming pixel; in_sof overrides the counters.
  always_comb begin
    accept = bus.in_valid & ~rst;
    cur_x  = bus.in_sof ? '0 : x_q;
    cur_y  = bus.in_sof ? '0 : y_q;
    x_d    = x_q;
    y_d    = y_q;
    if (accept) begin
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
    end
  end

  assign lb1_rd = lb1_mem[cur_x];
  assign lb2_rd = lb2_mem[cur_x];

  // Line buffers are never cleared: the row counter alone keeps stale lines
  // out of emitted windows, since emission needs y>=2.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_mem[cur_x] <= lb1_rd;
      lb1_mem[cur_x] <= bus.in_data;
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
      end
      win_d[2] = lb2_rd;
      win_d[5] = lb1_rd;
      win_d[8] = bus.in_data;
    end
  end

  // Stage 1: registered window output, loaded only for interior centres.
  always_comb begin
    emit      = accept && (cur_x >= X_MIN) && (cur_y >= Y_MIN);
    out_vld_d = emit;
    out_eof_d = emit && (cur_x == X_LAST) && (cur_y == Y_LAST);
    out_win_d = emit ? win_d : out_win_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      win_q     <= '0;
      out_win_q <= '0;
      out_vld_q <= 1'b0;
      out_eof_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      win_q     <= win_d;
      out_win_q <= out_win_d;
      out_vld_q <= out_vld_d;
      out_eof_q <= out_eof_d;
    end
  end

  assign bus.out_valid  = out_vld_q;
  assign bus.out_window = out_win_q;
  assign bus.out_eof    = out_eof_q;

endmodule

// File: tb/tb_gauss_window_gen.sv
// Scoreboard bench for gauss_window_gen on a 4x4 image with pixel = 4*y+x;
// expected windows come from a frame-image model, due one cycle after drive.
module tb_gauss_window_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct {
    logic [9*DW-1:0] win;
    logic            eof;
    int              due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gauss_window_gen_if #(.DATA_W(DW)) bus ();

  gauss_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t            sb_q[$];
  logic [DW-1:0]   img [H][W];
  int              mx = 0;
  int              my = 0;
  int              cyc = 0;
  int              n_checks = 0;
  int              n_fails = 0;
  int              nwin = 0;
  int              neof = 0;
  bit              mon_en = 0;
  bit              gapped = 0;
  logic            prev_vld = 0;
  logic [9*DW-1:0] last_win = '0;
  logic [9*DW-1:0] first_win = '0;
  logic [9*DW-1:0] ref_first;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [9*DW-1:0] act,
                          input logic [9*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Frame-image model: record the pixel, emit the window around (mx-1,my-1).
  task automatic model_accept(input logic [DW-1:0] d, input logic sof);
    exp_t e;
    if (sof) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = d;
    if (mx >= 2 && my >= 2) begin
      e.win = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.win[(3*r + c)*DW +: DW] = img[my - 2 + r][mx - 2 + c];
      e.eof = (mx == W - 1) && (my == H - 1);
      e.due = cyc + 1;
      sb_q.push_back(e);
    end
    if (mx == W - 1) begin
      mx = 0;
      my = (my == H - 1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
  endtask

  task automatic drive_px(input logic [DW-1:0] d, input logic sof);
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_data  = d;
    if (!rst) model_accept(d, sof);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pixels(input int n, input logic sof_first, input int gap);
    for (int i = 0; i < n; i++) begin
      drive_px(DW'(i), (i == 0) ? sof_first : 1'b0);
      if (gap > 0) idle(gap);
    end
  endtask

  // A pixel is presented during the reset cycle; it must be dropped.
  task automatic pulse_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    mx = 0;
    my = 0;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    last_win     = '0;
  endtask

  task automatic clear_counts();
    nwin = 0;
    neof = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("out_valid", {71'd0, bus.out_valid}, 72'd1);
        check_eq("out_window", bus.out_window, e.win);
        check_eq("out_eof", {71'd0, bus.out_eof}, {71'd0, e.eof});
        if (gapped) check_eq("back_to_back", {71'd0, prev_vld}, 72'd0);
        if (nwin == 0) first_win = bus.out_window;
        last_win = e.win;
        nwin++;
        if (bus.out_eof) neof++;
      end else begin
        check_eq("spurious_valid", {71'd0, bus.out_valid}, 72'd0);
        check_eq("window_hold", bus.out_window, last_win);
        check_eq("eof_idle", {71'd0, bus.out_eof}, 72'd0);
      end
      prev_vld = bus.out_valid;
    end
  end

  initial begin
    ref_first = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    idle(3);
    rst = 1'b0;
    check_eq("reset_valid", {71'd0, bus.out_valid}, 72'd0);
    check_eq("reset_eof", {71'd0, bus.out_eof}, 72'd0);
    check_eq("reset_window", bus.out_window, 72'd0);
    mon_en = 1;

    // Continuous frame.
    clear_counts();
    send_pixels(16, 1'b1, 0);
    idle(3);
    check_eq("frame_windows", nwin, 4);
    check_eq("frame_eofs", neof, 1);
    check_eq("first_window", first_win, ref_first);

    // Same frame with a bubble after every pixel.
    clear_counts();
    gapped = 1;
    send_pixels(16, 1'b1, 1);
    idle(3);
    gapped = 0;
    check_eq("gapped_windows", nwin, 4);
    check_eq("gapped_eofs", neof, 1);
    check_eq("gapped_first", first_win, ref_first);

    // Two back-to-back frames; the second relies on counter wrap.
    clear_counts();
    send_pixels(16, 1'b1, 0);
    send_pixels(16, 1'b0, 0);
    idle(3);
    check_eq("b2b_windows", nwin, 8);
    check_eq("b2b_eofs", neof, 2);

    // Frame aborted by in_sof at pixel 9.
    clear_counts();
    send_pixels(9, 1'b1, 0);
    send_pixels(16, 1'b1, 0);
    idle(3);
    check_eq("abort_windows", nwin, 4);
    check_eq("abort_eofs", neof, 1);
    check_eq("abort_first", first_win, ref_first);

    // Reset after pixel 7, then a frame without in_sof.
    clear_counts();
    send_pixels(8, 1'b1, 0);
    pulse_reset();
    check_eq("midrst_valid", {71'd0, bus.out_valid}, 72'd0);
    check_eq("midrst_window", bus.out_window, 72'd0);
    send_pixels(16, 1'b0, 0);
    idle(3);
    check_eq("rst_windows", nwin, 4);
    check_eq("rst_eofs", neof, 1);
    check_eq("rst_first", first_win, ref_first);

    check_eq("scoreboard_empty", sb_q.size(), 0);
    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gauss_window_gen.md
GAUSS_WINDOW_GEN -- requirements
Module: gauss_window_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 640, pixels per line; legal range 3..4096.
REQ-003 SHALL have parameter IMG_H, default 480, lines per frame; legal range 3..4096.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  pixel accepted this cycle when high.
REQ-007 SHALL have port in_sof  input  1  qualified by in_valid; marks the pixel as (x=0,y=0).
REQ-008 SHALL have port in_data  input  DATA_W  pixel, raster order.
REQ-009 SHALL have port out_valid  output  1  out_window holds a complete interior 3x3 window.
REQ-010 SHALL have port out_window  output  9*DATA_W  window; element k=3*r+c at bits [k*DATA_W +: DATA_W]; r=0 is the oldest line, c=0 is the oldest column.
REQ-011 SHALL have port out_eof  output  1  high together with out_valid on the last window of a frame.

Function
REQ-012 SHALL keep a column counter x (0..IMG_W-1) and a row counter y (0..IMG_H-1), advancing only on accepted pixels.
REQ-013 x SHALL wrap IMG_W-1 -> 0 and increment y; y SHALL wrap IMG_H-1 -> 0 when x wraps.
REQ-014 An accepted pixel with in_sof=1 SHALL be treated as (0,0); counters then continue from (1,0); line-buffer contents are not cleared.
REQ-015 SHALL hold two line buffers of depth IMG_W (line y-1 and line y-2), read and written at address x on each accepted pixel; old y-1 data moves to y-2.
REQ-016 SHALL hold a 3x3 register window that shifts one column per accepted pixel; new column = {line y-2[x], line y-1[x], in_data}.
REQ-017 Window and buffers SHALL NOT change on cycles with in_valid=0.
REQ-018 out_valid SHALL be registered: high in the cycle after an accepted pixel at x>=2 and y>=2, else low; latency is exactly 1 cycle.
REQ-019 The emitted window SHALL be centred on pixel (x-1,y-1) of the accepting pixel; no border padding; (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-020 out_eof SHALL be high only in the cycle out_valid is high for the pixel at (IMG_W-1, IMG_H-1).
REQ-021 out_window SHALL hold its value when out_valid is low; the output is not back-pressured and downstream must accept every window.
REQ-022 The first window after wrap from x=IMG_W-1 SHALL not mix columns across lines: windows are only emitted for x>=2, so stale columns are never output.
REQ-023 in_sof asserted mid-frame SHALL abort the frame: no out_eof for the aborted frame; the window at (0,0) is not emitted.

Reset
REQ-024 On rst=1 at a clock edge: x=0, y=0, out_valid=0, out_eof=0, out_window=0, window registers=0.
REQ-025 Line-buffer RAM contents SHALL NOT be reset; counter reset alone guarantees no window is output before two fresh lines are written.
REQ-026 rst SHALL take priority over in_valid in the same cycle; that pixel is dropped.
REQ-027 Reset mid-frame SHALL restart at (0,0) on the next accepted pixel, with or without in_sof.

Verification (IMG_W=4, IMG_H=4, DATA_W=8, pixel value = 4*y+x)
REQ-028 Continuous frame with in_sof on pixel 0 -> first out_valid the cycle after pixel 10; out_window elements k=0..8 = 0,1,2,4,5,6,8,9,10.
REQ-029 Same frame -> exactly 4 out_valid pulses, centres 5,6,9,10 (bottom-right elements 10,11,14,15); out_eof only with the last one.
REQ-030 Same frame with in_valid low every other cycle -> identical window sequence; out_valid never on consecutive cycles; out_window stable between pulses.
REQ-031 Two back-to-back frames -> 8 windows; the first window of frame 2 equals the first of frame 1; 2 out_eof pulses.
REQ-032 in_sof re-asserted at pixel 9 of frame 1 -> no out_eof in frame 1; output resumes per REQ-028 relative to the new frame start.
REQ-033 rst pulsed after pixel 7, then frame restarted -> out_valid=0 during and after reset until pixel 10 of the new frame; then windows per REQ-028.
